exp2_pwl_mc: RTL and testbench

- Multi-lane, fully pipelined 2^x unit for the GELU/softmax exponent path.
- Each lane does the following:
  - Splits a signed fixed-point input into integer and fractional parts.
  - Evaluates a piecewise-linear 2^frac from an on-chip, runtime-loadable segment table.
  - Scales the result by 2^int, with saturation and underflow flags.
- Successor to the single-lane fixed-LUT exponent unit. Adds lane count, segment count, rounding mode, ready/valid backpressure and a coefficient load port.

---
 rtl/exp2_pkg.sv | 30 +++
 rtl/exp2_pwl_mc_if.sv | 33 +++
 rtl/exp2_lane.sv | 111 +++++++++++
 rtl/exp2_pwl_mc.sv | 102 ++++++++++
 tb/tb_exp2_pwl_mc.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exp2_pkg.sv
// exp2_pkg: shared constants, coefficient type and width helpers for the exp2 PWL unit.
`default_nettype none

package exp2_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  localparam int DATA_W = 32;
  localparam int FRAC_Q = 26;

  function automatic int int_width(input int w, input int q);
    return w - q;
  endfunction

  localparam int INT_W = int_width(DATA_W, FRAC_Q);

  function automatic logic [63:0] one_q(input int q);
    return 64'd1 << q;
  endfunction

  // Table entries are stored at DATA_W; the top-level W must equal DATA_W.
  typedef struct packed {
    logic signed [DATA_W-1:0] k;
    logic signed [DATA_W-1:0] b;
  } coeff_t;

endpackage

`default_nettype wire

// File: rtl/exp2_pwl_mc_if.sv
// exp2_pwl_mc_if: data handshake, result and coefficient-load signals of the exp2 unit.
`default_nettype none

interface exp2_pwl_mc_if #(
  parameter int W        = 32,
  parameter int LANES    = 4,
  parameter int SEG_BITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*W-1:0]    x_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*W-1:0]    y_out;
  logic [LANES-1:0]      sat_out;
  logic [LANES-1:0]      uflow_out;
  logic                  cfg_we;
  logic [SEG_BITS-1:0]   cfg_addr;
  logic [W-1:0]          cfg_k;
  logic [W-1:0]          cfg_b;

  modport master (
    output in_valid, x_in, out_ready, cfg_we, cfg_addr, cfg_k, cfg_b,
    input  in_ready, out_valid, y_out, sat_out, uflow_out
  );

  modport slave (
    input  in_valid, x_in, out_ready, cfg_we, cfg_addr, cfg_k, cfg_b,
    output in_ready, out_valid, y_out, sat_out, uflow_out
  );
endinterface

`default_nettype wire

// File: rtl/exp2_lane.sv
// exp2_lane: one lane of the 3-stage 2^x datapath (split/lookup, linear eval, 2^int scale).
`default_nettype none

module exp2_lane
  import exp2_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int Q     = FRAC_Q,
  parameter int ROUND = ROUND_HALF_UP
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                en,
  input  wire logic [W-1:0]        x,
  input  wire logic signed [W-1:0] k,
  input  wire logic signed [W-1:0] b,
  output logic [W-1:0]             y,
  output logic                     sat,
  output logic                     uflow
);

  localparam int IW = int_width(W, Q);
  localparam logic signed [W+Q:0] RND = (ROUND == ROUND_HALF_UP) ?
      {{(W+1){1'b0}}, 1'b1, {(Q-1){1'b0}}} : '0;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [IW-1:0] s1_int, s2_int;
  logic [Q-1:0]         s1_frac;
  logic signed [W-1:0]  s1_k, s1_b, s2_lin;

  logic signed [W+Q:0]  prod, prod_sh;
  logic [W:0]           lin_wide;
  logic signed [W-1:0]  lin_c;

  always_comb begin
    prod     = $signed({{(W+1){1'b0}}, s1_frac}) * $signed({{(Q+1){s1_k[W-1]}}, s1_k});
    prod_sh  = (prod + RND) >>> Q;
    lin_wide = prod_sh[W:0] + {s1_b[W-1], s1_b};
    // Clamp the W+1-bit sum back into the signed W range.
    if (lin_wide[W] != lin_wide[W-1])
      lin_c = lin_wide[W] ? MINV : MAXV;
    else
      lin_c = lin_wide[W-1:0];
  end

  int                  sv;
  int                  sh;
  logic                ovf;
  logic signed [W-1:0] shl, shr;
  logic [W-1:0]        y_c;
  logic                sat_c, uflow_c;

  always_comb begin
    sv      = int'(s2_int);
    sh      = 0;
    ovf     = 1'b0;
    shl     = '0;
    shr     = '0;
    y_c     = s2_lin;
    sat_c   = 1'b0;
    uflow_c = 1'b0;
    if (sv >= 0) begin
      // Shifting back must reproduce lin exactly, otherwise bits or sign were lost.
      if (sv > W-1) begin
        ovf = (s2_lin != '0);
      end else begin
        shl = s2_lin <<< sv;
        ovf = ((shl >>> sv) != s2_lin);
      end
      if (ovf) begin
        sat_c = 1'b1;
        y_c   = s2_lin[W-1] ? MINV : MAXV;
      end else begin
        y_c = shl;
      end
    end else begin
      sh      = (-sv > W-1) ? W-1 : -sv;
      shr     = s2_lin >>> sh;
      y_c     = shr;
      uflow_c = !s2_lin[W-1] && (s2_lin != '0) && (shr == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_int  <= '0;
      s1_frac <= '0;
      s1_k    <= '0;
      s1_b    <= '0;
      s2_int  <= '0;
      s2_lin  <= '0;
      y       <= '0;
      sat     <= 1'b0;
      uflow   <= 1'b0;
    end else if (en) begin
      s1_int  <= x[W-1:Q];
      s1_frac <= x[Q-1:0];
      s1_k    <= k;
      s1_b    <= b;
      s2_int  <= s1_int;
      s2_lin  <= lin_c;
      y       <= y_c;
      sat     <= sat_c;
      uflow   <= uflow_c;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exp2_pwl_mc.sv
// exp2_pwl_mc: multi-lane pipelined 2^x with a shared runtime-loadable PWL segment table.
`default_nettype none

module exp2_pwl_mc
  import exp2_pkg::*;
#(
  parameter int W        = DATA_W,
  parameter int Q        = FRAC_Q,
  parameter int LANES    = 4,
  parameter int SEG_BITS = 3,
  parameter int ROUND    = ROUND_HALF_UP
) (
  input wire logic        clk,
  input wire logic        rst,
  exp2_pwl_mc_if.slave    bus
);

  localparam int           SEGS = 1 << SEG_BITS;
  localparam logic [W-1:0] ONE  = W'(one_q(Q));

  coeff_t table_q [SEGS];
  logic   s1_valid, s2_valid, s3_valid;
  logic   advance;

  assign advance       = !s3_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = s3_valid;

  // An unloaded entry (k=0, b=1.0) makes the result exactly 2^int.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEGS; i++) begin
        table_q[i].k <= '0;
        table_q[i].b <= ONE;
      end
    end else if (bus.cfg_we) begin
      table_q[bus.cfg_addr].k <= bus.cfg_k;
      table_q[bus.cfg_addr].b <= bus.cfg_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  logic [W-1:0] y_arr   [LANES];
  logic         sat_arr [LANES];
  logic         uf_arr  [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SEG_BITS-1:0] seg;
    coeff_t              cf;

    assign seg = bus.x_in[i*W + Q - 1 -: SEG_BITS];
    assign cf  = table_q[seg];

    exp2_lane #(
      .W     (W),
      .Q     (Q),
      .ROUND (ROUND)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .x     (bus.x_in[i*W +: W]),
      .k     (cf.k),
      .b     (cf.b),
      .y     (y_arr[i]),
      .sat   (sat_arr[i]),
      .uflow (uf_arr[i])
    );
  end

  logic [LANES*W-1:0] y_all;
  logic [LANES-1:0]   sat_all, uf_all;

  always_comb begin
    y_all   = '0;
    sat_all = '0;
    uf_all  = '0;
    for (int i = 0; i < LANES; i++) begin
      y_all[i*W +: W] = y_arr[i];
      sat_all[i]      = sat_arr[i];
      uf_all[i]       = uf_arr[i];
    end
  end

  assign bus.y_out     = y_all;
  assign bus.sat_out   = sat_all;
  assign bus.uflow_out = uf_all;

endmodule

`default_nettype wire

// File: tb/tb_exp2_pwl_mc.sv
// tb_exp2_pwl_mc: scoreboard bench for exp2_pwl_mc (W=32, Q=26, 4 lanes, 8 segments, round-half-up).
`default_nettype none

module tb_exp2_pwl_mc;

  localparam int W = 32, Q = 26, LANES = 4, SEG_BITS = 3, LW = LANES * W;
  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  typedef struct packed {
    logic [LW-1:0]    y;
    logic [LANES-1:0] sat;
    logic [LANES-1:0] uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exp2_pwl_mc_if #(.W(W), .LANES(LANES), .SEG_BITS(SEG_BITS)) bus();

  exp2_pwl_mc #(.W(W), .Q(Q), .LANES(LANES), .SEG_BITS(SEG_BITS), .ROUND(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           tests = 0;
  int           fails = 0;
  int           n_out = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] mk [8];
  logic [W-1:0] mb [8];

  function automatic logic [LW-1:0] rep(input logic [W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic exp_t mkexp(input logic [LW-1:0] y, input logic [LANES-1:0] s, input logic [LANES-1:0] u);
    exp_t e;
    e.y = y; e.sat = s; e.uf = u;
    return e;
  endfunction

  // Reference 2^x for one lane using wide integer arithmetic; returns {sat, uflow, y}.
  function automatic logic [W+1:0] model_lane(input logic [W-1:0] x);
    longint s, fr, p, lin, r;
    int sg, sh;
    logic st, u;
    logic [W-1:0] y;
    s   = longint'($signed(x)) >>> Q;
    fr  = longint'(x[Q-1:0]);
    sg  = int'(x[Q-1 -: SEG_BITS]);
    p   = fr * longint'($signed(mk[sg])) + (longint'(1) << (Q-1));
    lin = (p >>> Q) + longint'($signed(mb[sg]));
    if (lin > MAXL) lin = MAXL;
    else if (lin < MINL) lin = MINL;
    st = 1'b0; u = 1'b0;
    if (s >= 0) begin
      r = lin <<< s;
      if (r > MAXL || r < MINL) begin
        st = 1'b1;
        y  = (lin < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        y = r[W-1:0];
      end
    end else begin
      sh = (-s > W-1) ? W-1 : int'(-s);
      r  = lin >>> sh;
      y  = r[W-1:0];
      u  = (lin > 0) && (r == 0);
    end
    return {st, u, y};
  endfunction

  function automatic exp_t model_beat(input logic [LW-1:0] xv);
    exp_t e;
    logic [W+1:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = model_lane(xv[i*W +: W]);
      e.y[i*W +: W] = r[W-1:0];
      e.uf[i]       = r[W];
      e.sat[i]      = r[W+1];
    end
    return e;
  endfunction

  task automatic reset_mirror();
    for (int i = 0; i < 8; i++) begin
      mk[i] = 32'h0;
      mb[i] = 32'h0400_0000;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out y=%h with empty scoreboard, required no output", bus.y_out);
      end else begin
        mon_e = sb.pop_front();
        n_out++;
        if (bus.y_out !== mon_e.y) begin
          fails++;
          $display("FAIL sb_y got %h required %h", bus.y_out, mon_e.y);
        end
        tests++;
        if (bus.sat_out !== mon_e.sat) begin
          fails++;
          $display("FAIL sb_sat got %b required %b", bus.sat_out, mon_e.sat);
        end
        tests++;
        if (bus.uflow_out !== mon_e.uf) begin
          fails++;
          $display("FAIL sb_uflow got %b required %b", bus.uflow_out, mon_e.uf);
        end
      end
    end
  end

  task automatic send(input logic [LW-1:0] xv, input bit use_model, input exp_t e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in     = xv;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=0 for 200 cycles, required 1");
    end else begin
      sb.push_back(use_model ? model_beat(xv) : e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [SEG_BITS-1:0] a, input logic [W-1:0] k, input logic [W-1:0] b);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_k = k; bus.cfg_b = b;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    mk[a] = k; mb[a] = b;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.x_in = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_k = '0; bus.cfg_b = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_mirror();
  endtask

  task automatic test_reset();
    do_reset();
    tests += 5;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b required 0", bus.out_valid); end
    if (bus.y_out !== '0) begin fails++; $display("FAIL rst_y got %h required 0", bus.y_out); end
    if (bus.sat_out !== '0) begin fails++; $display("FAIL rst_sat got %b required 0", bus.sat_out); end
    if (bus.uflow_out !== '0) begin fails++; $display("FAIL rst_uflow got %b required 0", bus.uflow_out); end
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b required 1", bus.in_ready); end
  endtask

  task automatic test_default_table();
    send(rep(32'h0000_0000), 1'b0, mkexp(rep(32'h0400_0000), '0, '0));
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (bus.out_valid !== (c == 2)) begin
        fails++;
        $display("FAIL latency cycle%0d out_valid got %b required %b", c, bus.out_valid, (c == 2));
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    send(rep(32'h0600_0000), 1'b0, mkexp(rep(32'h0800_0000), '0, '0));
    drain();
  endtask

  task automatic load_table();
    for (int s = 0; s < 8; s++) cfg_write(SEG_BITS'(s), 32'h0400_0000, 32'h0400_0000);
  endtask

  task automatic test_loaded();
    send(rep(32'h0600_0000), 1'b0, mkexp(rep(32'h0C00_0000), '0, '0));
    send(rep(32'hF800_0000), 1'b0, mkexp(rep(32'h0100_0000), '0, '0));
    send(rep(32'h1400_0000), 1'b0, mkexp(rep(32'h7FFF_FFFF), '1, '0));
    send(rep(32'h8400_0000), 1'b0, mkexp(rep(32'h0000_0000), '0, '1));
    drain();
  endtask

  task automatic test_lanes();
    send({32'h1400_0000, 32'hF800_0000, 32'h0600_0000, 32'h0000_0000}, 1'b0,
         mkexp({32'h7FFF_FFFF, 32'h0100_0000, 32'h0C00_0000, 32'h0400_0000}, 4'b1000, 4'b0000));
    drain();
  endtask

  task automatic test_back_to_back();
    int n0 = n_out;
    logic [LW-1:0] cap;
    logic [LW-1:0] xv;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int bt = 0; bt < 6; bt++) begin
          for (int i = 0; i < LANES; i++)
            xv[i*W +: W] = 32'(i) * 32'h0100_0000 + 32'(bt) * 32'h0090_0000 - 32'h0400_0000;
          send(xv, 1'b1, '0);
        end
      end
      begin
        for (int c = 1; c <= 5; c++) begin
          @(posedge clk); #1;
          if (c >= 3) begin
            tests += 3;
            if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d got %b required 0", c, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid c%0d got %b required 1", c, bus.out_valid); end
            if (c == 3) cap = bus.y_out;
            else if (bus.y_out !== cap) begin fails++; $display("FAIL bp_hold c%0d got %h required %h", c, bus.y_out, cap); end
          end
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    tests++;
    if (n_out - n0 != 6) begin fails++; $display("FAIL bp_count got %0d required 6", n_out - n0); end
  endtask

  task automatic test_table_update();
    bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_k = 32'h0; bus.cfg_b = 32'h0800_0000;
    send(rep(32'h0), 1'b0, mkexp(rep(32'h0400_0000), '0, '0));
    bus.cfg_we = 1'b0;
    mk[0] = 32'h0; mb[0] = 32'h0800_0000;
    send(rep(32'h0), 1'b0, mkexp(rep(32'h0800_0000), '0, '0));
    drain();
  endtask

  task automatic test_random();
    logic [LW-1:0] xv;
    for (int s = 0; s < 8; s++) begin
      if (s % 2 == 0) cfg_write(SEG_BITS'(s), ($urandom & 32'h07FF_FFFF) - 32'h0400_0000, ($urandom & 32'h07FF_FFFF));
      else cfg_write(SEG_BITS'(s), $urandom, $urandom);
    end
    fork
      begin
        for (int bt = 0; bt < 24; bt++) begin
          for (int i = 0; i < LANES; i++) begin
            if (i % 2 == 0)
              xv[i*W +: W] = ($urandom & 32'h03FF_FFFF) | ((32'($urandom_range(0, 7)) - 32'd4) << 26);
            else
              xv[i*W +: W] = $urandom;
          end
          send(xv, 1'b1, '0);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    bus.out_ready = 1'b1;
    send(rep(32'h0600_0000), 1'b1, '0);
    send(rep(32'hF800_0000), 1'b1, '0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_flush got %b required 0", bus.out_valid); end
    rst = 1'b0;
    reset_mirror();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_stale got out_valid=1 after reset, required 0"); end
    send(rep(32'h0600_0000), 1'b0, mkexp(rep(32'h0800_0000), '0, '0));
    drain();
  endtask

  initial begin
    test_reset();
    test_default_table();
    load_table();
    test_loaded();
    test_lanes();
    test_back_to_back();
    test_table_update();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
